vend_arbiter: RTL

- Controller that shares the single food-vending datapath between two customer panels, A and B.
- Arbitrates panel requests round-robin and latches the winner's choice and money.
- Checks price and stock, sequences a fixed-length dispense, then reports the item, the change and the per-item availability.
- Sits between the panel input logic and the dispenser/display outputs of the vending top level.

---
 rtl/vend_arbiter_if.sv | 42 ++++
 rtl/vend_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter_if.sv
// Panel/dispenser bus of the vending arbiter.
// Handshake: a panel holds req_x high (level) with stable choice_x/money_x;
// the arbiter accepts on a clock edge and answers with gnt_x from the next
// cycle. gnt_x stays high until the transaction's DONE cycle has passed;
// req_x changes while gnt_x is high are ignored. done pulses for exactly one
// cycle and item/remaining_money/fail are valid from that cycle onward.
interface vend_arbiter_if;
    logic       req_a;
    logic [2:0] choice_a;
    logic [2:0] money_a;
    logic       req_b;
    logic [2:0] choice_b;
    logic [2:0] money_b;
    logic       restock;
    logic       gnt_a;
    logic       gnt_b;
    logic       busy;
    logic [2:0] item;
    logic [2:0] remaining_money;
    logic       fail;
    logic       done;
    logic [2:0] available_item;
    logic [1:0] state_dbg;

    // Panel / top-level side: drives requests and restock, observes results.
    modport master (
        output req_a, choice_a, money_a,
        output req_b, choice_b, money_b,
        output restock,
        input  gnt_a, gnt_b, busy, item, remaining_money,
        input  fail, done, available_item, state_dbg
    );

    // Arbiter side.
    modport slave (
        input  req_a, choice_a, money_a,
        input  req_b, choice_b, money_b,
        input  restock,
        output gnt_a, gnt_b, busy, item, remaining_money,
        output fail, done, available_item, state_dbg
    );
endinterface

// File: rtl/vend_arbiter.sv
// Two-panel vending controller: round-robin arbitration between panels A and
// B, price/stock check, fixed-length dispense, change and availability report.
module vend_arbiter #(
    parameter logic [2:0] PRICE1      = 3'd2,
    parameter logic [2:0] PRICE2      = 3'd3,
    parameter logic [2:0] PRICE3      = 3'd5,
    parameter logic [2:0] INIT_STOCK  = 3'd3,
    parameter logic [3:0] DISP_CYCLES = 4'd4
) (
    input  logic         clk,
    input  logic         rst,
    vend_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [3:0] DISP_LOAD = DISP_CYCLES - 4'd1;

    state_t     state;
    state_t     state_nxt;

    // stock[0..2] holds items 1..3
    logic [2:0] stock [3];
    logic [2:0] choice_q;
    logic [2:0] money_q;
    logic       ptr_b;          // 0: A has priority on a tie, 1: B
    logic       restock_pend;
    logic [3:0] disp_cnt;
    logic       gnt_a_q;
    logic       gnt_b_q;
    logic [2:0] item_q;
    logic [2:0] rem_q;
    logic       fail_q;

    logic       restock_req;
    logic       any_req;
    logic       win_b;
    logic       accept;
    logic       choice_valid;
    logic [2:0] sel_stock;
    logic [2:0] sel_price;
    logic       check_ok;
    logic       last_disp;

    // Arbitration and price/stock decode for the latched transaction.
    always_comb begin
        restock_req  = bus.restock | restock_pend;
        any_req      = bus.req_a | bus.req_b;
        // B wins when it is alone, or when both ask and the pointer names B.
        win_b        = bus.req_b & (~bus.req_a | ptr_b);
        choice_valid = (choice_q >= 3'd1) && (choice_q <= 3'd3);
        sel_stock    = 3'd0;
        sel_price    = 3'd0;
        case (choice_q)
            3'd1: begin sel_stock = stock[0]; sel_price = PRICE1; end
            3'd2: begin sel_stock = stock[1]; sel_price = PRICE2; end
            3'd3: begin sel_stock = stock[2]; sel_price = PRICE3; end
            default: begin sel_stock = 3'd0; sel_price = 3'd0; end
        endcase
        check_ok  = choice_valid && (sel_stock != 3'd0) && (money_q >= sel_price);
        last_disp = (disp_cnt == 4'd0);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state; a pending restock blocks acceptance in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!restock_req && any_req) begin
                    accept    = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = check_ok ? S_DISPENSE : S_DONE;
            end
            S_DISPENSE: begin
                if (last_disp) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Restock: reload in IDLE, otherwise remember the request until IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            restock_pend <= 1'b0;
        end else if (state == S_IDLE) begin
            restock_pend <= 1'b0;
        end else if (bus.restock) begin
            restock_pend <= 1'b1;
        end
    end

    // Stock registers: reload on restock in IDLE, decrement on a passed check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                stock[i] <= INIT_STOCK;
            end
        end else if (state == S_IDLE && restock_req) begin
            for (int i = 0; i < 3; i++) begin
                stock[i] <= INIT_STOCK;
            end
        end else if (state == S_CHECK && check_ok) begin
            for (int i = 0; i < 3; i++) begin
                if (choice_q == 3'(i + 1)) begin
                    stock[i] <= stock[i] - 3'd1;
                end
            end
        end
    end

    // Winner latch, round-robin pointer and grant hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            choice_q <= 3'd0;
            money_q  <= 3'd0;
            ptr_b    <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else if (accept) begin
            choice_q <= win_b ? bus.choice_b : bus.choice_a;
            money_q  <= win_b ? bus.money_b  : bus.money_a;
            ptr_b    <= ~win_b;
            gnt_a_q  <= ~win_b;
            gnt_b_q  <= win_b;
        end else if (state == S_DONE) begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end
    end

    // Dispense counter: loaded on a passed check, counts down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_cnt <= 4'd0;
        end else if (state == S_CHECK && check_ok) begin
            disp_cnt <= DISP_LOAD;
        end else if (state == S_DISPENSE && !last_disp) begin
            disp_cnt <= disp_cnt - 4'd1;
        end
    end

    // Result registers: written on a rejected check or the last dispense cycle,
    // then held until the next transaction writes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            item_q <= 3'd0;
            rem_q  <= 3'd0;
            fail_q <= 1'b0;
        end else if (state == S_CHECK && !check_ok) begin
            item_q <= 3'd0;
            rem_q  <= money_q;
            fail_q <= 1'b1;
        end else if (state == S_DISPENSE && last_disp) begin
            item_q <= choice_q;
            rem_q  <= money_q - sel_price;
            fail_q <= 1'b0;
        end
    end

    // Output mapping; availability follows the stock registers directly.
    always_comb begin
        bus.gnt_a           = gnt_a_q;
        bus.gnt_b           = gnt_b_q;
        bus.busy            = (state != S_IDLE);
        bus.done            = (state == S_DONE);
        bus.item            = item_q;
        bus.remaining_money = rem_q;
        bus.fail            = fail_q;
        bus.available_item  = {stock[2] != 3'd0, stock[1] != 3'd0, stock[0] != 3'd0};
        bus.state_dbg       = state;
    end

endmodule
